imu_sensor_regfile: RTL and testbench



---
 rtl/imu_regs_pkg.sv | 21 ++
 rtl/imu_channel.sv | 94 +++++++++
 rtl/imu_sensor_regfile.sv | 118 +++++++++++
 tb/tb_imu_sensor_regfile.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_regs_pkg.sv
// Register map constants shared by the IMU sensor register file and its channels.
// Latency: none, constants only.
// Backpressure: none, constants only.
package imu_regs_pkg;

  typedef logic [3:0] reg_addr_t;

  // Word addresses on the Avalon-MM slave
  localparam reg_addr_t ADDR_STATUS  = 4'd0;
  localparam reg_addr_t ADDR_CONTROL = 4'd1;
  localparam reg_addr_t ADDR_COUNT   = 4'd2;
  localparam reg_addr_t ADDR_DATA0   = 4'd3;

  // STATUS word layout
  localparam int NEW_LSB = 0;
  localparam int OVR_LSB = 16;

  // CONTROL word: averaging enable lives in the top bit
  localparam int AVG_EN_BIT = 31;

endpackage

// File: rtl/imu_channel.sv
// One sensor channel: optional 2^AVG_LOG2 boxcar average, held result, sticky NEW/OVR flags.
// Latency: held value and flags update one edge after the strobe that completes a window.
// Backpressure: none; strobes while disabled are dropped, unread results are overwritten and flagged OVR.
module imu_channel
  import imu_regs_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 3,
  parameter bit SIGNED   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              enable,
  input  logic              avg_en,
  input  logic              clear,
  input  logic              read_clear,
  output logic [31:0]       value,
  output logic              new_flag,
  output logic              ovr_flag,
  output logic              commit
);

  // Accumulator is exactly wide enough for 2^AVG_LOG2 samples of either signedness
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  sample_ext;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] held_q;
  logic [DATA_W-1:0] result;
  logic              new_q;
  logic              ovr_q;
  logic              accept;
  logic              avg_mode;
  logic              last;

  // Window arithmetic; the top DATA_W bits of the sum are the shifted, truncated average
  // (identical for arithmetic and logical shift because the sum is exactly ACC_W bits)
  always_comb begin
    if (SIGNED) sample_ext = ACC_W'($signed(sample_data));
    else        sample_ext = ACC_W'(sample_data);
    sum      = acc_q + sample_ext;
    accept   = sample_valid & enable;
    avg_mode = avg_en && (AVG_LOG2 > 0);
    last     = &cnt_q;
    commit   = accept && (!avg_mode || last);
    result   = avg_mode ? sum[ACC_W-1 -: DATA_W] : sample_data;
  end

  // Accumulator, window counter, held value and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      held_q <= '0;
      new_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (accept && avg_mode) begin
        if (last) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (commit) held_q <= result;
      // A commit sets NEW even when the host reads in the same cycle
      if (commit)          new_q <= 1'b1;
      else if (read_clear) new_q <= 1'b0;
      // A read always clears OVR; an unread result that gets replaced raises it
      if (read_clear)             ovr_q <= 1'b0;
      else if (commit && new_q)   ovr_q <= 1'b1;
    end
  end

  // Extend the held result onto the 32-bit bus
  always_comb begin
    if (SIGNED) value = 32'($signed(held_q));
    else        value = 32'(held_q);
  end

  assign new_flag = new_q;
  assign ovr_flag = ovr_q;

endmodule

// File: rtl/imu_sensor_regfile.sv
// Avalon-MM register file exposing N_CH IMU channels (STATUS, CONTROL, COUNT, DATA[c] from word 3).
// Latency: readdata registered, valid one edge after chipselect&read; writes take effect on their edge.
// Backpressure: none; no wait-states, sample strobes are never stalled.
module imu_sensor_regfile
  import imu_regs_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 3,
  parameter bit SIGNED   = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipselect,
  input  logic [3:0]             addr,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic [N_CH*DATA_W-1:0] sample_data,
  input  logic [N_CH-1:0]        sample_valid
);

  logic            rd_en;
  logic            wr_ctrl;
  logic [N_CH-1:0] en_q;
  logic            avg_en_q;
  logic [31:0]     count_q;
  logic [N_CH-1:0] commit_vec;
  logic [N_CH-1:0] new_vec;
  logic [N_CH-1:0] ovr_vec;
  logic [N_CH-1:0] clear_vec;
  logic [N_CH-1:0] rd_clr_vec;
  logic [31:0]     ch_value [N_CH];
  logic [3:0]      n_commit;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign rd_en        = chipselect & read;
  assign wr_ctrl      = chipselect & write & (addr == ADDR_CONTROL);
  assign unused_wdata = ^writedata;

  // Per-channel window clear on CONTROL writes, read-clear on DATA reads, commit popcount
  always_comb begin
    n_commit = '0;
    for (int c = 0; c < N_CH; c++) begin
      clear_vec[c]  = wr_ctrl && ((writedata[AVG_EN_BIT] != avg_en_q) || (en_q[c] && !writedata[c]));
      rd_clr_vec[c] = rd_en && (addr == ADDR_DATA0 + 4'(c));
      n_commit      = n_commit + 4'(commit_vec[c]);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    imu_channel #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2),
      .SIGNED   (SIGNED)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .sample_data  (sample_data[c*DATA_W +: DATA_W]),
      .sample_valid (sample_valid[c]),
      .enable       (en_q[c]),
      .avg_en       (avg_en_q),
      .clear        (clear_vec[c]),
      .read_clear   (rd_clr_vec[c]),
      .value        (ch_value[c]),
      .new_flag     (new_vec[c]),
      .ovr_flag     (ovr_vec[c]),
      .commit       (commit_vec[c])
    );
  end

  // CONTROL register: channel enables default on, averaging default off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= '1;
      avg_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      en_q     <= writedata[N_CH-1:0];
      avg_en_q <= writedata[AVG_EN_BIT];
    end
  end

  // COUNT: running total of committed results, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_q + 32'(n_commit);
  end

  // Read mux from pre-edge state, so same-cycle commits are not yet visible
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_STATUS: begin
        rd_mux[NEW_LSB +: N_CH] = new_vec;
        rd_mux[OVR_LSB +: N_CH] = ovr_vec;
      end
      ADDR_CONTROL: begin
        rd_mux[N_CH-1:0]  = en_q;
        rd_mux[AVG_EN_BIT] = avg_en_q;
      end
      ADDR_COUNT: rd_mux = count_q;
      default: begin
        for (int c = 0; c < N_CH; c++) begin
          if (addr == ADDR_DATA0 + 4'(c)) rd_mux = ch_value[c];
        end
      end
    endcase
  end

  // readdata loads only on a qualified read and holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_imu_sensor_regfile.sv
module tb_imu_sensor_regfile;

  localparam int N_CH = 4;
  localparam int DW   = 12;
  localparam int WIN  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            chipselect = 1'b0;
  logic [3:0]      addr = '0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic [N_CH*DW-1:0] sample_data = '0;
  logic [N_CH-1:0] sample_valid = '0;

  int n_checks = 0;
  int n_fail   = 0;

  imu_sensor_regfile #(
    .N_CH(N_CH), .DATA_W(DW), .AVG_LOG2(3), .SIGNED(1'b1)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .addr         (addr),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .sample_data  (sample_data),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (integer values, window queues) ----------------
  logic [N_CH-1:0] m_en;
  logic            m_avg;
  logic [N_CH-1:0] m_new;
  logic [N_CH-1:0] m_ovr;
  int              m_held [N_CH];
  int              m_win  [N_CH][$];
  logic [31:0]     m_count;
  logic [31:0]     m_rd;

  function automatic int sx(input logic [DW-1:0] x);
    return int'($signed(x));
  endfunction

  task automatic model_reset();
    m_en = '1; m_avg = 1'b0; m_new = '0; m_ovr = '0; m_count = '0; m_rd = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_held[c] = 0;
      m_win[c].delete();
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 4'd0) begin
      for (int c = 0; c < N_CH; c++) begin
        r[c] = m_new[c];
        r[16+c] = m_ovr[c];
      end
    end else if (a == 4'd1) begin
      r[N_CH-1:0] = m_en;
      r[31] = m_avg;
    end else if (a == 4'd2) begin
      r = m_count;
    end else if (a >= 4'd3 && a < 4'(3 + N_CH)) begin
      r = m_held[int'(a) - 3];
    end
    return r;
  endfunction

  task automatic model_step(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                            input logic [31:0] wd, input logic [N_CH-1:0] v, input logic [N_CH*DW-1:0] d);
    int  val;
    int  sum;
    logic com;
    logic rdc;
    if (cs && rd) m_rd = model_read(a);
    for (int c = 0; c < N_CH; c++) begin
      com = 1'b0;
      val = 0;
      if (v[c] && m_en[c]) begin
        if (!m_avg) begin
          com = 1'b1;
          val = sx(d[c*DW +: DW]);
        end else begin
          m_win[c].push_back(sx(d[c*DW +: DW]));
          if (m_win[c].size() == WIN) begin
            sum = 0;
            foreach (m_win[c][k]) sum += m_win[c][k];
            val = sx(DW'(sum >>> 3));
            com = 1'b1;
            m_win[c].delete();
          end
        end
      end
      rdc = cs && rd && (a == 4'(3 + c));
      if (com) begin
        if (rdc)           m_ovr[c] = 1'b0;
        else if (m_new[c]) m_ovr[c] = 1'b1;
        m_new[c]  = 1'b1;
        m_held[c] = val;
        m_count   = m_count + 32'd1;
      end else if (rdc) begin
        m_new[c] = 1'b0;
        m_ovr[c] = 1'b0;
      end
    end
    if (cs && wr && a == 4'd1) begin
      for (int c = 0; c < N_CH; c++)
        if ((wd[31] != m_avg) || (m_en[c] && !wd[c])) m_win[c].delete();
      m_en  = wd[N_CH-1:0];
      m_avg = wd[31];
    end
  endtask

  // ---------------- bench helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic [N_CH-1:0] v, input logic [N_CH*DW-1:0] d);
    @(negedge clk);
    chipselect = cs; read = rd; write = wr; addr = a; writedata = wd;
    sample_valid = v; sample_data = d;
    @(posedge clk);
    model_step(cs, rd, wr, a, wd, v, d);
    #1;
    check("readdata_vs_model", readdata, m_rd);
    chipselect = 1'b0; read = 1'b0; write = 1'b0; sample_valid = '0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string name);
    cyc(1'b1, 1'b1, 1'b0, a, 32'd0, '0, '0);
    check(name, readdata, exp);
  endtask

  task automatic wr_ctrl(input logic [31:0] wd);
    cyc(1'b1, 1'b0, 1'b1, 4'd1, wd, '0, '0);
  endtask

  task automatic strobe(input int ch, input logic [DW-1:0] val, input logic do_rd, input logic [3:0] ra);
    logic [N_CH*DW-1:0] d;
    d = '0;
    d[ch*DW +: DW] = val;
    cyc(do_rd, do_rd, 1'b0, ra, 32'd0, N_CH'(1 << ch), d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; sample_valid = '0;
    #1;
    check("async_reset_readdata", readdata, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t rst_tab [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      rst_tab[i].addr = 4'(i);
      rst_tab[i].exp  = (i == 1) ? 32'h0000_000F : 32'h0;
    end

    model_reset();
    do_reset();

    // Reset readback over the full address space
    foreach (rst_tab[i]) rd_chk(rst_tab[i].addr, rst_tab[i].exp, "reset_readback");

    // Direct commit, signed extension, NEW cleared by DATA read
    strobe(0, 12'hFFF, 1'b0, 4'd0);
    rd_chk(4'd0, 32'h0000_0001, "status_new0_before_read");
    rd_chk(4'd3, 32'hFFFF_FFFF, "data0_signed_ext");
    rd_chk(4'd0, 32'h0, "status_new0_after_read");

    // Averaging window of 8 on ch1
    wr_ctrl(32'h8000_000F);
    rd_chk(4'd1, 32'h8000_000F, "control_readback");
    for (int k = 1; k <= 7; k++) strobe(1, DW'(10 * k), 1'b0, 4'd0);
    rd_chk(4'd0, 32'h0, "no_commit_after_7th");
    rd_chk(4'd4, 32'h0, "data1_before_8th");
    strobe(1, DW'(80), 1'b1, 4'd0);
    check("status_precommit_at_8th", readdata, 32'h0);
    rd_chk(4'd0, 32'h0000_0002, "new1_after_8th");
    rd_chk(4'd4, 32'd45, "avg_data1");

    // Overrun, then DATA read colliding with a commit
    wr_ctrl(32'h0000_000F);
    strobe(2, DW'(100), 1'b0, 4'd0);
    strobe(2, DW'(200), 1'b0, 4'd0);
    rd_chk(4'd0, 32'h0004_0004, "status_ovr2");
    strobe(2, DW'(300), 1'b1, 4'd5);
    check("read_old_value_on_commit", readdata, 32'd200);
    rd_chk(4'd0, 32'h0000_0004, "new2_set_ovr2_clear");
    rd_chk(4'd5, 32'd300, "data2_third");
    rd_chk(4'd0, 32'h0, "status_clear");

    // Disabled channel ignored, multi-channel COUNT step, COUNT wrap
    wr_ctrl(32'h0000_000E);
    strobe(0, 12'h123, 1'b0, 4'd0);
    rd_chk(4'd3, 32'hFFFF_FFFF, "disabled_ch0_holds");
    rd_chk(4'd0, 32'h0, "disabled_ch0_no_new");
    rd_chk(4'd2, 32'd5, "count_before_multi");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'b1110, {12'd7, 12'd6, 12'd5, 12'd4});
    rd_chk(4'd2, 32'd8, "count_plus3");
    @(negedge clk);
    force u_dut.count_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.count_q;
    m_count = 32'hFFFF_FFFE;
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'b1110, {12'd1, 12'd2, 12'd3, 12'd4});
    rd_chk(4'd2, 32'd1, "count_wrap");

    // Reset in the middle of a window, then a fresh negative window (floor toward -inf)
    wr_ctrl(32'h8000_000F);
    for (int k = 0; k < 5; k++) strobe(3, DW'(1000), 1'b0, 4'd0);
    do_reset();
    foreach (rst_tab[i]) rd_chk(rst_tab[i].addr, rst_tab[i].exp, "midwindow_reset_readback");
    wr_ctrl(32'h8000_000F);
    for (int k = 0; k < 3; k++) strobe(3, 12'hFFF, 1'b0, 4'd0);
    rd_chk(4'd0, 32'h0, "no_residue_after_3");
    for (int k = 0; k < 4; k++) strobe(3, 12'hFFF, 1'b0, 4'd0);
    strobe(3, 12'h000, 1'b0, 4'd0);
    rd_chk(4'd0, 32'h0000_0008, "new3_fresh_window");
    rd_chk(4'd6, 32'hFFFF_FFFF, "avg_floor_negative");
    rd_chk(4'd2, 32'd1, "count_after_reset");

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic        cs_r;
      logic        rd_r;
      logic        wr_r;
      logic [3:0]  a_r;
      logic [31:0] wd_r;
      cs_r = ($urandom_range(0, 3) != 0);
      wr_r = ($urandom_range(0, 24) == 0);
      rd_r = !wr_r && ($urandom_range(0, 1) == 1);
      a_r  = wr_r ? 4'd1 : 4'($urandom_range(0, 8));
      wd_r = $urandom();
      if ($urandom_range(0, 1) == 1) wd_r[N_CH-1:0] = '1;
      cyc(cs_r, rd_r, wr_r, a_r, wd_r, N_CH'($urandom()), (N_CH*DW)'({$urandom(), $urandom()}));
    end
    for (int a = 0; a < 8; a++) rd_chk(4'(a), model_read(4'(a)), "final_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
